// File: rtl/regfile_param_pkg.sv
// ============================================================================
// Module      : regfile_param_pkg
// Description : Shared constants and helpers for the parametrised register file
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_param_pkg;

    localparam int BYTE_W     = 8;

    // Default instance shape: MIPS general-purpose register file
    localparam int GPR_DEPTH  = 32;
    localparam int GPR_WIDTH  = 32;
    localparam int GPR_NUM_RD = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_param_reg_cell.sv
// ============================================================================
// Module      : reg_cell
// Description : Enable-gated register with synchronous active-high reset
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_cell #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_param.sv
// ============================================================================
// Module      : regfile_param
// Description : Multi-port register file with byte strobes, optional zero
//               entry and optional write-to-read bypass
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int  WIDTH     = GPR_WIDTH,
    parameter int  DEPTH     = GPR_DEPTH,
    parameter int  NUM_RD    = GPR_NUM_RD,
    parameter int  ZERO_REG0 = 1,
    parameter int  BYPASS    = 0,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WE,
    input  logic [AW-1:0]            WADDR,
    input  logic [WIDTH/BYTE_W-1:0]  WSTRB,
    input  logic [WIDTH-1:0]         WDATA,
    input  logic [NUM_RD*AW-1:0]     RADDR,
    output logic [NUM_RD*WIDTH-1:0]  RDATA,
    output logic                     WR_ACCEPT
);

    localparam int NB = WIDTH / BYTE_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             waddr_writable;
    logic             bypass_on;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;
    logic             wr_accept_q;

    assign waddr_writable = !((ZERO_REG0 != 0) && (WADDR == '0));

    // Entry 0 has no storage at all when hardwired to zero
    generate
        for (genvar e = 0; e < DEPTH; e++) begin : g_entry
            if ((ZERO_REG0 != 0) && (e == 0)) begin : g_zero
                assign mem[e] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] q;
                logic             hit;

                assign hit = WE && (WADDR == AW'(e));

                for (genvar k = 0; k < NB; k++) begin : g_lane
                    reg_cell #(
                        .W (BYTE_W)
                    ) u_cell (
                        .CLK (CLK),
                        .RST (RST),
                        .EN  (hit && WSTRB[k]),
                        .D   (WDATA[k*BYTE_W +: BYTE_W]),
                        .Q   (q[k*BYTE_W +: BYTE_W])
                    );
                end

                assign mem[e] = q;
            end
        end
    endgenerate

    assign wr_old    = mem[WADDR];
    assign bypass_on = (BYPASS != 0) && WE && !RST && waddr_writable;

    generate
        for (genvar k = 0; k < NB; k++) begin : g_merge
            assign wr_merged[k*BYTE_W +: BYTE_W] = WSTRB[k] ? WDATA[k*BYTE_W +: BYTE_W]
                                                            : wr_old[k*BYTE_W +: BYTE_W];
        end
    endgenerate

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [AW-1:0] ra;

            assign ra = RADDR[p*AW +: AW];
            assign RDATA[p*WIDTH +: WIDTH] = (bypass_on && (ra == WADDR)) ? wr_merged : mem[ra];
        end
    endgenerate

    // A write counts only if some byte of a writable entry actually changed hands
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_accept_q <= 1'b0;
        end else begin
            wr_accept_q <= WE && waddr_writable && (|WSTRB);
        end
    end

    assign WR_ACCEPT = wr_accept_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// Module      : tb_regfile_param
// Description : Self-checking bench for regfile_param (three configurations)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 32x32 instances
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata_a;
    logic [63:0] rdata_b;
    logic        acc_a;
    logic        acc_b;

    // Stimulus for the 64-bit x 8 x 3-port instance
    logic        we_c;
    logic [2:0]  waddr_c;
    logic [7:0]  wstrb_c;
    logic [63:0] wdata_c;
    logic [8:0]  raddr_c;
    logic [191:0] rdata_c;
    logic        acc_c;

    // a: zero entry, no bypass
    regfile_param #(
        .WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG0(1), .BYPASS(0)
    ) dut_a (
        .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .WSTRB(wstrb), .WDATA(wdata),
        .RADDR(raddr), .RDATA(rdata_a), .WR_ACCEPT(acc_a)
    );

    // b: ordinary entry 0, bypass
    regfile_param #(
        .WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG0(0), .BYPASS(1)
    ) dut_b (
        .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .WSTRB(wstrb), .WDATA(wdata),
        .RADDR(raddr), .RDATA(rdata_b), .WR_ACCEPT(acc_b)
    );

    // c: wide, shallow, three read ports, zero entry and bypass
    regfile_param #(
        .WIDTH(64), .DEPTH(8), .NUM_RD(3), .ZERO_REG0(1), .BYPASS(1)
    ) dut_c (
        .CLK(clk), .RST(rst), .WE(we_c), .WADDR(waddr_c), .WSTRB(wstrb_c), .WDATA(wdata_c),
        .RADDR(raddr_c), .RDATA(rdata_c), .WR_ACCEPT(acc_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference contents and expected accept flags
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic [63:0] mc [8];
    logic        acc_a_e;
    logic        acc_b_e;
    logic        acc_c_e;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] nw,
                                                input logic [7:0] strb);
        logic [63:0] res;
        res = old;
        for (int k = 0; k < 8; k++) begin
            if (strb[k]) res[k*8 +: 8] = nw[k*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] exp_a(input logic [4:0] ad);
        return (ad == 5'd0) ? 32'h0 : ma[ad];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] ad);
        logic [63:0] t;
        if (we && !rst && (ad == waddr)) begin
            t = merge_bytes({32'h0, mb[ad]}, {32'h0, wdata}, {4'h0, wstrb});
            return t[31:0];
        end
        return mb[ad];
    endfunction

    function automatic logic [63:0] exp_c(input logic [2:0] ad);
        if (ad == 3'd0) return 64'h0;
        if (we_c && !rst && (ad == waddr_c)) return merge_bytes(mc[ad], wdata_c, wstrb_c);
        return mc[ad];
    endfunction

    // Advance one clock edge and apply the architectural update rules to the models
    task automatic step();
        @(posedge clk);
        if (rst) begin
            foreach (ma[i]) ma[i] = 32'h0;
            foreach (mb[i]) mb[i] = 32'h0;
            foreach (mc[i]) mc[i] = 64'h0;
            acc_a_e = 1'b0;
            acc_b_e = 1'b0;
            acc_c_e = 1'b0;
        end else begin
            logic [63:0] t;
            acc_a_e = we && (waddr != 5'd0) && (wstrb != 4'h0);
            if (acc_a_e) begin
                t = merge_bytes({32'h0, ma[waddr]}, {32'h0, wdata}, {4'h0, wstrb});
                ma[waddr] = t[31:0];
            end
            acc_b_e = we && (wstrb != 4'h0);
            if (acc_b_e) begin
                t = merge_bytes({32'h0, mb[waddr]}, {32'h0, wdata}, {4'h0, wstrb});
                mb[waddr] = t[31:0];
            end
            acc_c_e = we_c && (waddr_c != 3'd0) && (wstrb_c != 8'h0);
            if (acc_c_e) mc[waddr_c] = merge_bytes(mc[waddr_c], wdata_c, wstrb_c);
        end
        #1;
    endtask

    task automatic test_reset();
        we = 1'b1; wstrb = 4'hF; wdata = 32'hA5A5A5A5;
        for (int a = 1; a < 32; a++) begin
            waddr = 5'(a);
            step();
        end
        rst = 1'b1; waddr = 5'd5; wdata = 32'hFFFFFFFF; raddr = {5'd6, 5'd5};
        #1;
        n_checks++;
        if (rdata_b[31:0] !== 32'hA5A5A5A5)
            $display("FAIL reset_no_bypass: got %h expected %h", rdata_b[31:0], 32'hA5A5A5A5);
        else n_pass++;
        step();
        rst = 1'b0; we = 1'b0;
        n_checks++;
        if (acc_a !== 1'b0 || acc_b !== 1'b0 || acc_c !== 1'b0)
            $display("FAIL reset_accept: got %b%b%b expected 000", acc_a, acc_b, acc_c);
        else n_pass++;
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            #1;
            n_checks++;
            if (rdata_a !== 64'h0 || rdata_b !== 64'h0)
                $display("FAIL reset_read addr %0d: got %h/%h expected 0", a, rdata_a, rdata_b);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        we = 1'b1; waddr = 5'd7; wstrb = 4'hF; wdata = 32'hDEADBEEF;
        step();
        we = 1'b0; raddr = {5'd7, 5'd7};
        #1;
        n_checks++;
        if (rdata_a !== {2{32'hDEADBEEF}} || rdata_b !== {2{32'hDEADBEEF}})
            $display("FAIL basic_read: got %h/%h expected %h", rdata_a, rdata_b, {2{32'hDEADBEEF}});
        else n_pass++;
        n_checks++;
        if (acc_a !== 1'b1 || acc_b !== 1'b1)
            $display("FAIL basic_accept: got %b%b expected 11", acc_a, acc_b);
        else n_pass++;
        step();
        n_checks++;
        if (acc_a !== 1'b0 || acc_b !== 1'b0)
            $display("FAIL basic_accept_pulse: got %b%b expected 00", acc_a, acc_b);
        else n_pass++;
    endtask

    task automatic test_strobes();
        we = 1'b1; waddr = 5'd9; wstrb = 4'hF; wdata = 32'h11223344;
        step();
        wstrb = 4'b0101; wdata = 32'hAABBCCDD;
        step();
        we = 1'b0; raddr = {5'd9, 5'd9};
        #1;
        n_checks++;
        if (rdata_a[31:0] !== 32'h11BB33DD || rdata_b[63:32] !== 32'h11BB33DD)
            $display("FAIL strobe_merge: got %h/%h expected %h", rdata_a[31:0], rdata_b[63:32], 32'h11BB33DD);
        else n_pass++;
        we = 1'b1; wstrb = 4'h0; wdata = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata_a[31:0] !== 32'h11BB33DD || rdata_b[31:0] !== 32'h11BB33DD)
            $display("FAIL strobe_zero_hold: got %h/%h expected %h", rdata_a[31:0], rdata_b[31:0], 32'h11BB33DD);
        else n_pass++;
        n_checks++;
        if (acc_a !== 1'b0 || acc_b !== 1'b0)
            $display("FAIL strobe_zero_accept: got %b%b expected 00", acc_a, acc_b);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 5'd0; wstrb = 4'hF; wdata = 32'h12345678; raddr = 10'd0;
        #1;
        n_checks++;
        if (rdata_a !== 64'h0)
            $display("FAIL zero_same_cycle: got %h expected 0", rdata_a);
        else n_pass++;
        step();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata_a !== 64'h0 || acc_a !== 1'b0)
            $display("FAIL zero_reg: got %h acc %b expected 0 acc 0", rdata_a, acc_a);
        else n_pass++;
        n_checks++;
        if (rdata_b !== {2{32'h12345678}} || acc_b !== 1'b1)
            $display("FAIL zero_disabled: got %h acc %b expected %h acc 1", rdata_b, acc_b, {2{32'h12345678}});
        else n_pass++;
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd3; wstrb = 4'b0011; wdata = 32'hCAFEF00D; raddr = {5'd4, 5'd3};
        #1;
        n_checks++;
        if (rdata_b !== {32'h0, 32'h0000F00D})
            $display("FAIL bypass_on: got %h expected %h", rdata_b, {32'h0, 32'h0000F00D});
        else n_pass++;
        n_checks++;
        if (rdata_a !== 64'h0)
            $display("FAIL bypass_off_same: got %h expected 0", rdata_a);
        else n_pass++;
        step();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata_a[31:0] !== 32'h0000F00D || rdata_b[31:0] !== 32'h0000F00D)
            $display("FAIL bypass_next: got %h/%h expected %h", rdata_a[31:0], rdata_b[31:0], 32'h0000F00D);
        else n_pass++;
        rst = 1'b1; we = 1'b1; wstrb = 4'hF; wdata = 32'h12345678; raddr = {5'd3, 5'd3};
        #1;
        n_checks++;
        if (rdata_b[31:0] !== 32'h0000F00D)
            $display("FAIL bypass_in_reset: got %h expected %h", rdata_b[31:0], 32'h0000F00D);
        else n_pass++;
        step();
        rst = 1'b0; we = 1'b0;
        #1;
        n_checks++;
        if (rdata_b !== 64'h0 || rdata_a !== 64'h0)
            $display("FAIL bypass_reset_drop: got %h/%h expected 0", rdata_b, rdata_a);
        else n_pass++;
    endtask

    task automatic test_random_gpr();
        logic [4:0] p0;
        logic [4:0] p1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst   = ($urandom_range(0, 49) == 0);
            we    = ($urandom_range(0, 3) != 0);
            waddr = 5'($urandom);
            wstrb = 4'($urandom);
            wdata = $urandom;
            p0 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            p1 = ($urandom_range(0, 3) == 0) ? p0 : 5'($urandom);
            raddr = {p1, p0};
            if (!we && $urandom_range(0, 7) == 0) begin
                waddr = 'x;
                wdata = 'x;
            end
            #1;
            n_checks++;
            if (rdata_a !== {exp_a(p1), exp_a(p0)})
                $display("FAIL rand_a cyc %0d: got %h expected %h", cyc, rdata_a, {exp_a(p1), exp_a(p0)});
            else n_pass++;
            n_checks++;
            if (rdata_b !== {exp_b(p1), exp_b(p0)})
                $display("FAIL rand_b cyc %0d: got %h expected %h", cyc, rdata_b, {exp_b(p1), exp_b(p0)});
            else n_pass++;
            n_checks++;
            if (acc_a !== acc_a_e || acc_b !== acc_b_e)
                $display("FAIL rand_accept cyc %0d: got %b%b expected %b%b", cyc, acc_a, acc_b, acc_a_e, acc_b_e);
            else n_pass++;
            step();
        end
        rst = 1'b0; we = 1'b0;
    endtask

    task automatic test_sweep();
        logic [2:0] p0;
        logic [2:0] p1;
        logic [2:0] p2;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst     = ($urandom_range(0, 99) == 0);
            we_c    = ($urandom_range(0, 3) != 0);
            waddr_c = 3'($urandom);
            wstrb_c = 8'($urandom);
            wdata_c = {$urandom, $urandom};
            p0 = ($urandom_range(0, 2) == 0) ? waddr_c : 3'($urandom);
            p1 = ($urandom_range(0, 3) == 0) ? p0 : 3'($urandom);
            p2 = ($urandom_range(0, 3) == 0) ? p1 : 3'($urandom);
            raddr_c = {p2, p1, p0};
            #1;
            n_checks++;
            if (rdata_c !== {exp_c(p2), exp_c(p1), exp_c(p0)})
                $display("FAIL sweep_read cyc %0d: got %h expected %h", cyc, rdata_c,
                         {exp_c(p2), exp_c(p1), exp_c(p0)});
            else n_pass++;
            n_checks++;
            if (acc_c !== acc_c_e)
                $display("FAIL sweep_accept cyc %0d: got %b expected %b", cyc, acc_c, acc_c_e);
            else n_pass++;
            step();
        end
        rst = 1'b0; we_c = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wstrb = '0; wdata = '0; raddr = '0;
        we_c = 1'b0; waddr_c = '0; wstrb_c = '0; wdata_c = '0; raddr_c = '0;
        acc_a_e = 1'b0; acc_b_e = 1'b0; acc_c_e = 1'b0;
        foreach (ma[i]) ma[i] = 32'h0;
        foreach (mb[i]) mb[i] = 32'h0;
        foreach (mc[i]) mc[i] = 64'h0;
        step();
        step();
        rst = 1'b0;
        step();

        test_reset();
        test_basic();
        test_strobes();
        test_zero_reg();
        test_bypass();
        test_random_gpr();
        test_sweep();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised multi-port register file: the next generation of the single-bit/32-bit flip-flop registers.
- Adds the following over a plain register:
  - write enable
  - per-byte write strobes
  - synchronous reset
  - a hardwired-zero entry
  - N combinational read ports with optional write-to-read bypass
- Used as the MIPS GPR file (DEPTH=32, WIDTH=32, NUM_RD=2) and reusable for CP0/scratch banks.

Parameters:
- WIDTH, 32, bits per entry; must be a multiple of 8.
- DEPTH, 32, number of entries; power of two, at least 2.
- NUM_RD, 2, number of independent read ports, 1..4.
- ZERO_REG0, 1, when 1, entry 0 always reads 0 and ignores writes.
- BYPASS, 0, when 1, a read of the address being written this cycle returns the masked new data.
- AW, log2(DEPTH), derived address width (localparam, not overridable).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- WE  in  1  write enable.
- WADDR  in  AW  write address.
- WSTRB  in  WIDTH/8  byte write strobes; bit k covers WDATA[8k+7:8k].
- WDATA  in  WIDTH  write data.
- RADDR  in  NUM_RD*AW  packed read addresses; port p uses [p*AW +: AW].
- RDATA  out  NUM_RD*WIDTH  packed read data; port p uses [p*WIDTH +: WIDTH].
- WR_ACCEPT  out  1  registered pulse: high the cycle after a write actually modified an entry.

Behaviour:
- Reset:
  - Synchronous only: RST sampled on the CLK rising edge.
  - All entries clear to 0 and WR_ACCEPT clears to 0.
  - RST has priority over WE in the same cycle; that write is dropped.
  - RDATA shows 0 for every address from the first edge with RST high.
- Write: on the rising edge with WE=1, RST=0 and the entry writable, entry[WADDR] byte k takes WDATA byte k for each WSTRB[k]=1. Bytes with WSTRB[k]=0 hold.
- Write latency: a write is visible on RDATA the cycle after the edge (BYPASS=0).
- WSTRB all-zero with WE=1 is legal: no entry changes and WR_ACCEPT stays 0.
- ZERO_REG0=1:
  - Writes to address 0 are discarded and WR_ACCEPT stays 0.
  - RDATA for address 0 is constant 0 regardless of history.
- ZERO_REG0=0: entry 0 behaves like any other entry.
- Read: combinational and asynchronous in address; no read enable; all ports are fully independent, and identical addresses on multiple ports are legal.
- BYPASS=1: if WE=1, RST=0 and RADDR_p==WADDR (writable), RDATA_p shows the merged value, i.e. new bytes where WSTRB=1 and stored bytes elsewhere, in the same cycle.
- BYPASS never applies during RST=1 or for address 0 when ZERO_REG0=1.
- WR_ACCEPT: registered. It is 1 in cycle n+1 iff cycle n performed a write with at least one strobe set to a writable entry.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- X on WADDR/WDATA with WE=0 must not corrupt state.
- No internal state machine beyond per-entry storage and the WR_ACCEPT flop.
- Storage is built from the byte-lane cell below. Behavioural arrays are acceptable only behind the same cell interface.

Decomposition:
- Shared include regfile_defs.vh holds:
  - BYTE_W=8
  - the clog2 function/macro for AW
  - the GPR instance constants: GPR_DEPTH=32, GPR_WIDTH=32, GPR_NUM_RD=2.
- One sub-module, reg_cell:
  - Parameters: W.
  - Ports: CLK, RST (sync), EN, D, Q.
  - Generic enable-gated sync-reset register.
  - Instantiated per byte lane per entry. Its EN = WE & decode(WADDR) & WSTRB[k] & writable.
- Read muxes and bypass merge stay in regfile_param via generate loops over NUM_RD.

Test Plan:
- Reset:
  - Stimulus: pre-load entries 1..31 with 0xA5A5A5A5, then hold RST=1 for one edge while also WE=1, WADDR=5, WDATA=0xFFFFFFFF.
  - Required: every read returns 0x00000000 after the edge and WR_ACCEPT=0.
- Basic write/read:
  - Stimulus: WE=1, WADDR=7, WSTRB=0xF, WDATA=0xDEADBEEF; next cycle RADDR0=7, RADDR1=7.
  - Required: both ports 0xDEADBEEF and WR_ACCEPT=1 for exactly one cycle.
- Byte strobes:
  - Stimulus: entry 9 holds 0x11223344; write WSTRB=0b0101, WDATA=0xAABBCCDD.
  - Required: entry 9 reads 0x11BB33DD.
  - Stimulus: then WSTRB=0 with WE=1.
  - Required: entry 9 unchanged and WR_ACCEPT=0.
- Zero register (ZERO_REG0=1):
  - Stimulus: write 0x12345678 to address 0.
  - Required: RDATA for address 0 = 0 and WR_ACCEPT=0.
  - Stimulus: rebuild with ZERO_REG0=0 and repeat.
  - Required: reads 0x12345678.
- Bypass:
  - Stimulus: BYPASS=1, entry 3 holds 0x00000000; same cycle WE=1, WADDR=3, WSTRB=0b0011, WDATA=0xCAFEF00D, RADDR0=3, RADDR1=4.
  - Required: port0=0x0000F00D combinationally that cycle and port1 unaffected.
  - Stimulus: BYPASS=0, same stimulus.
  - Required: port0=0 that cycle and 0x0000F00D the next.
- Parameter sweep:
  - Stimulus: WIDTH=64, DEPTH=8, NUM_RD=3; random writes/reads for 10k cycles with RST asserted randomly.
  - Required: all ports match a reference scoreboard every cycle, including simultaneous identical read addresses.
